// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped burst-refill instruction cache:
// FSM state encoding and address-field width helpers.
package icache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REFILL   = 2'd1,
    ST_ACK      = 2'd2,
    ST_ACK_MISS = 2'd3
  } state_e;

  function automatic int calc_off_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int calc_idx_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  // The two low address bits select a byte within a word and never reach the tag.
  function automatic int calc_tag_w(input int addr_w, input int line_words, input int num_lines);
    return addr_w - $clog2(line_words) - $clog2(num_lines) - 2;
  endfunction

endpackage

// File: rtl/icache_line_ram.sv
// Cache data storage: one 32-bit word per {line index, word offset},
// synchronous write, combinational read.
module icache_line_ram #(
  parameter int AW    = 5,
  parameter int DEPTH = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/icache_dm_burst.sv
// Direct-mapped instruction cache between the Wishbone fetch port and the
// BRAM controller; misses refill a whole line from an in-order beat stream.
module icache_dm_burst
  import icache_pkg::*;
#(
  parameter int LINE_WORDS = 8,
  parameter int NUM_LINES  = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [ADDR_W-1:0] wbs_adr_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic              cache_flush,
  output logic              refill_req,
  output logic [ADDR_W-1:0] refill_adr,
  input  logic [31:0]       bram_data_in,
  input  logic              bram_in_valid
);

  localparam int OFF_W  = calc_off_w(LINE_WORDS);
  localparam int IDX_W  = calc_idx_w(NUM_LINES);
  localparam int IDX_B  = (IDX_W > 0) ? IDX_W : 1;
  localparam int TAG_W  = calc_tag_w(ADDR_W, LINE_WORDS, NUM_LINES);
  localparam int RAM_AW = OFF_W + IDX_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  // Handshakes: a read transfer is stb&cyc&~we held until the single-cycle
  // ack; refill beats are accepted whenever bram_in_valid is high in REFILL
  // (no back-pressure), and refill_req stays high until the last beat lands.
  state_e state, state_nx;

  logic              req, wr, hit, beat, last_beat, ack;
  logic [OFF_W-1:0]  a_off, lat_off, cnt;
  logic [IDX_B-1:0]  a_idx, lat_idx;
  logic [TAG_W-1:0]  a_tag, lat_tag;
  logic [TAG_W-1:0]  tag_mem [NUM_LINES];
  logic [NUM_LINES-1:0] valid;
  logic              flush_seen;
  logic [31:0]       dat_q, ram_rdata;
  logic [RAM_AW-1:0] ram_raddr, ram_waddr;
  logic [ADDR_W-1:0] refill_base;
  logic              unused_adr;

  assign req        = wbs_stb_i & wbs_cyc_i & ~wbs_we_i;
  assign wr         = wbs_stb_i & wbs_cyc_i & wbs_we_i;
  assign a_off      = wbs_adr_i[OFF_W+1:2];
  assign a_tag      = wbs_adr_i[ADDR_W-1:OFF_W+IDX_W+2];
  assign unused_adr = ^wbs_adr_i[1:0];

  generate
    if (IDX_W > 0) begin : g_idx
      assign a_idx       = wbs_adr_i[OFF_W+IDX_W+1:OFF_W+2];
      assign ram_raddr   = {a_idx, a_off};
      assign ram_waddr   = {lat_idx, cnt};
      assign refill_base = {lat_tag, lat_idx, {(OFF_W+2){1'b0}}};
    end else begin : g_no_idx
      assign a_idx       = '0;
      assign ram_raddr   = a_off;
      assign ram_waddr   = cnt;
      assign refill_base = {lat_tag, {(OFF_W+2){1'b0}}};
    end
  endgenerate

  assign hit       = valid[a_idx] && (tag_mem[a_idx] == a_tag);
  assign beat      = (state == ST_REFILL) && bram_in_valid;
  assign last_beat = beat && (cnt == LAST_BEAT);

  icache_line_ram #(
    .AW    (RAM_AW),
    .DEPTH (NUM_LINES * LINE_WORDS)
  ) u_line_ram (
    .clk   (clk),
    .we    (beat),
    .waddr (ram_waddr),
    .wdata (bram_data_in),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:     if (req) state_nx = hit ? ST_ACK : ST_REFILL;
      ST_REFILL:   if (last_beat) state_nx = ST_ACK_MISS;
      ST_ACK:      state_nx = ST_IDLE;
      ST_ACK_MISS: state_nx = ST_IDLE;
      default:     state_nx = ST_IDLE;
    endcase
  end

  // An abandoned miss still finishes the refill but must not ack a dead transfer.
  always_comb begin
    ack        = 1'b0;
    refill_req = 1'b0;
    case (state)
      ST_ACK:      ack = 1'b1;
      ST_ACK_MISS: ack = req;
      ST_REFILL:   refill_req = 1'b1;
      default:     ;
    endcase
  end

  assign wbs_ack_o  = ack;
  assign wbs_dat_o  = ack ? dat_q : 32'd0;
  assign refill_adr = refill_req ? refill_base : '0;

  // The requested word is captured from the beat stream as it passes, so the
  // miss ack needs no second RAM read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      lat_off    <= '0;
      lat_idx    <= '0;
      lat_tag    <= '0;
      dat_q      <= '0;
      flush_seen <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            if (hit) begin
              dat_q <= ram_rdata;
            end else begin
              lat_idx    <= a_idx;
              lat_tag    <= a_tag;
              lat_off    <= a_off;
              cnt        <= '0;
              flush_seen <= 1'b0;
            end
          end
        end
        ST_REFILL: begin
          if (cache_flush) flush_seen <= 1'b1;
          if (beat) begin
            cnt <= cnt + OFF_W'(1);
            if (cnt == lat_off) dat_q <= bram_data_in;
          end
        end
        default: ;
      endcase
    end
  end

  // A flush anywhere during the refill leaves the completed line invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else if (cache_flush) begin
      valid <= '0;
    end else if ((state == ST_IDLE) && wr && hit) begin
      valid[a_idx] <= 1'b0;
    end else if (last_beat && !flush_seen) begin
      valid[lat_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (last_beat) tag_mem[lat_idx] <= lat_tag;
  end

endmodule

// File: tb/tb_icache_dm_burst.sv
// Directed plus randomized bench for icache_dm_burst, checked against a
// line-level behavioural model of the cache contents.
module tb_icache_dm_burst;
  import icache_pkg::*;

  localparam int LW         = 8;
  localparam int NL         = 4;
  localparam int AW         = 32;
  localparam int LINE_BYTES = LW * 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [AW-1:0] wbs_adr_i;
  logic          wbs_ack_o;
  logic [31:0]   wbs_dat_o;
  logic          cache_flush;
  logic          refill_req;
  logic [AW-1:0] refill_adr;
  logic [31:0]   bram_data_in;
  logic          bram_in_valid;

  int total = 0;
  int bad   = 0;

  // Model: which lines hold which tag and the words they were filled with.
  bit          mv    [NL];
  int unsigned mtag  [NL];
  logic [31:0] mdata [NL][LW];

  always #5 clk = ~clk;

  icache_dm_burst #(
    .LINE_WORDS (LW),
    .NUM_LINES  (NL),
    .ADDR_W     (AW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wbs_stb_i     (wbs_stb_i),
    .wbs_cyc_i     (wbs_cyc_i),
    .wbs_we_i      (wbs_we_i),
    .wbs_adr_i     (wbs_adr_i),
    .wbs_ack_o     (wbs_ack_o),
    .wbs_dat_o     (wbs_dat_o),
    .cache_flush   (cache_flush),
    .refill_req    (refill_req),
    .refill_adr    (refill_adr),
    .bram_data_in  (bram_data_in),
    .bram_in_valid (bram_in_valid)
  );

  function automatic int m_idx(input logic [31:0] a);
    return int'((a / 32'(LINE_BYTES)) % 32'(NL));
  endfunction

  function automatic int m_off(input logic [31:0] a);
    return int'((a / 32'd4) % 32'(LW));
  endfunction

  function automatic int unsigned m_tag(input logic [31:0] a);
    return a / 32'(LINE_BYTES * NL);
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int j = 0; j < NL; j++) mv[j] = 1'b0;
  endtask

  // abandon_at / flush_at / rst_at select the beat at which that event is
  // applied; -1 disables it. rnd_data also enables random gaps between beats.
  task automatic cpu_read(input logic [31:0] a, input bit rnd_data, input logic [31:0] seed,
                          input int abandon_at, input int flush_at, input int rst_at);
    int          idx, off;
    int unsigned tg;
    bit          hit, flushed, live;
    logic [31:0] line [LW];
    logic [31:0] base;
    idx  = m_idx(a);
    off  = m_off(a);
    tg   = m_tag(a);
    hit  = mv[idx] && (mtag[idx] == tg);
    base = a & ~32'(LINE_BYTES - 1);
    wbs_adr_i = a;
    wbs_stb_i = 1'b1;
    wbs_cyc_i = 1'b1;
    wbs_we_i  = 1'b0;
    step();
    if (hit) begin
      chk("hit_ack", 32'(wbs_ack_o), 32'd1);
      chk("hit_dat", wbs_dat_o, mdata[idx][off]);
      chk("hit_no_refill", 32'(refill_req), 32'd0);
      wbs_stb_i = 1'b0;
      wbs_cyc_i = 1'b0;
      step();
      chk("hit_ack_drop", 32'(wbs_ack_o), 32'd0);
      chk("hit_dat_zero", wbs_dat_o, 32'd0);
      return;
    end
    chk("miss_refill_req", 32'(refill_req), 32'd1);
    chk("miss_refill_adr", refill_adr, base);
    chk("miss_no_ack", 32'(wbs_ack_o), 32'd0);
    flushed = 1'b0;
    live    = 1'b1;
    for (int i = 0; i < LW; i++) begin
      if (rnd_data && $urandom_range(0, 3) == 0) begin
        bram_in_valid = 1'b0;
        bram_data_in  = $urandom;
        step();
        chk("gap_refill_req", 32'(refill_req), 32'd1);
      end
      line[i]       = rnd_data ? $urandom : seed + 32'(i);
      bram_data_in  = line[i];
      bram_in_valid = 1'b1;
      if (i == abandon_at) begin
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        live      = 1'b0;
      end
      if (i == flush_at) begin
        cache_flush = 1'b1;
        flushed     = 1'b1;
        model_clear();
      end
      if (i == rst_at) begin
        bram_in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_refill_req", 32'(refill_req), 32'd0);
        chk("rst_refill_adr", refill_adr, 32'd0);
        chk("rst_ack", 32'(wbs_ack_o), 32'd0);
        chk("rst_dat", wbs_dat_o, 32'd0);
        chk("rst_state", 32'(dut.state), 32'(ST_IDLE));
        model_clear();
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        #2;
        rst = 1'b0;
        return;
      end
      step();
      cache_flush = 1'b0;
      if (i < LW - 1) begin
        chk("refill_hold", 32'(refill_req), 32'd1);
        chk("refill_no_ack", 32'(wbs_ack_o), 32'd0);
      end
    end
    bram_in_valid = 1'b0;
    chk("miss_ack", 32'(wbs_ack_o), 32'(live));
    chk("miss_dat", wbs_dat_o, live ? line[off] : 32'd0);
    chk("miss_refill_drop", 32'(refill_req), 32'd0);
    chk("miss_refill_adr_zero", refill_adr, 32'd0);
    mtag[idx] = tg;
    for (int j = 0; j < LW; j++) mdata[idx][j] = line[j];
    if (!flushed) mv[idx] = 1'b1;
    wbs_stb_i = 1'b0;
    wbs_cyc_i = 1'b0;
    step();
    chk("miss_ack_drop", 32'(wbs_ack_o), 32'd0);
  endtask

  task automatic cpu_write(input logic [31:0] a);
    int idx;
    idx = m_idx(a);
    wbs_adr_i = a;
    wbs_stb_i = 1'b1;
    wbs_cyc_i = 1'b1;
    wbs_we_i  = 1'b1;
    step();
    chk("wr_no_ack", 32'(wbs_ack_o), 32'd0);
    chk("wr_no_refill", 32'(refill_req), 32'd0);
    wbs_stb_i = 1'b0;
    wbs_cyc_i = 1'b0;
    wbs_we_i  = 1'b0;
    if (mv[idx] && mtag[idx] == m_tag(a)) mv[idx] = 1'b0;
  endtask

  task automatic do_flush();
    cache_flush = 1'b1;
    step();
    cache_flush = 1'b0;
    model_clear();
    chk("flush_no_ack", 32'(wbs_ack_o), 32'd0);
  endtask

  initial begin
    int          op, ab, fl;
    logic [31:0] ra;
    rst           = 1'b1;
    wbs_stb_i     = 1'b0;
    wbs_cyc_i     = 1'b0;
    wbs_we_i      = 1'b0;
    wbs_adr_i     = '0;
    cache_flush   = 1'b0;
    bram_data_in  = '0;
    bram_in_valid = 1'b0;
    model_clear();
    step();
    step();
    chk("reset_ack", 32'(wbs_ack_o), 32'd0);
    chk("reset_dat", wbs_dat_o, 32'd0);
    chk("reset_refill_req", 32'(refill_req), 32'd0);
    chk("reset_refill_adr", refill_adr, 32'd0);
    chk("reset_state", 32'(dut.state), 32'(ST_IDLE));
    #3;
    rst = 1'b0;
    step();

    // Cold miss, then a hit in the same line.
    cpu_read(32'h0000_0024, 1'b0, 32'hA0, -1, -1, -1);
    chk("plan_line1_word1", mdata[1][1], 32'hA1);
    cpu_read(32'h0000_0038, 1'b0, 32'h0, -1, -1, -1);

    // Conflict eviction on index 1, then the original line misses again.
    cpu_read(32'h0000_00A0, 1'b0, 32'hB0, -1, -1, -1);
    cpu_read(32'h0000_0020, 1'b0, 32'hC0, -1, -1, -1);

    // Write invalidation.
    cpu_write(32'h0000_0024);
    cpu_read(32'h0000_0024, 1'b0, 32'hC8, -1, -1, -1);

    // Flush during refill: acked, but the line is left invalid.
    cpu_read(32'h0000_0044, 1'b0, 32'hD0, -1, 3, -1);
    cpu_read(32'h0000_0044, 1'b0, 32'hE0, -1, -1, -1);

    // Abandon mid-refill: no ack, line still becomes valid.
    cpu_read(32'h0000_0064, 1'b0, 32'hF0, 4, -1, -1);
    cpu_read(32'h0000_0064, 1'b0, 32'h0, -1, -1, -1);

    // A request held through the ack is re-evaluated only after an idle cycle.
    wbs_adr_i = 32'h0000_0068;
    wbs_stb_i = 1'b1;
    wbs_cyc_i = 1'b1;
    step();
    chk("hold_ack1", 32'(wbs_ack_o), 32'd1);
    chk("hold_dat1", wbs_dat_o, mdata[3][2]);
    step();
    chk("hold_idle_gap", 32'(wbs_ack_o), 32'd0);
    step();
    chk("hold_ack2", 32'(wbs_ack_o), 32'd1);
    chk("hold_dat2", wbs_dat_o, mdata[3][2]);
    wbs_stb_i = 1'b0;
    wbs_cyc_i = 1'b0;
    step();

    // Reset mid-refill, then previously valid lines miss.
    cpu_read(32'h0000_0184, 1'b1, 32'h0, -1, -1, 3);
    step();
    cpu_read(32'h0000_0184, 1'b0, 32'h1000, -1, -1, -1);
    cpu_read(32'h0000_0064, 1'b0, 32'h2000, -1, -1, -1);

    // Stray beats outside a refill must not disturb cached data.
    bram_in_valid = 1'b1;
    bram_data_in  = 32'hDEAD_BEEF;
    step();
    step();
    bram_in_valid = 1'b0;
    chk("stray_beat_no_refill", 32'(refill_req), 32'd0);
    cpu_read(32'h0000_0188, 1'b0, 32'h0, -1, -1, -1);

    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 9);
      ra = 32'($urandom_range(0, 511));
      if (op == 0) begin
        cpu_write(ra);
      end else if (op == 1) begin
        do_flush();
      end else begin
        ab = ($urandom_range(0, 7) == 0) ? $urandom_range(0, LW - 1) : -1;
        fl = ($urandom_range(0, 7) == 0) ? $urandom_range(0, LW - 1) : -1;
        cpu_read(ra, 1'b1, 32'h0, ab, fl, -1);
      end
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/icache_dm_burst.md
Name: icache_dm_burst

Overview:
- Parametrised direct-mapped instruction cache between the CPU Wishbone instruction fetch port and the BRAM controller.
- Holds NUM_LINES lines of LINE_WORDS 32-bit words each, with per-line tag and valid bit.
- Read hits are acknowledged one cycle after request. Read misses issue a burst refill request, fill the whole line from the BRAM stream, then acknowledge.
- Writes bypass the cache and invalidate a matching line. An external flush clears all lines.

Parameters:
- LINE_WORDS, 8, words per line; power of two, >=2
- NUM_LINES, 4, lines in cache; power of two, >=1
- ADDR_W, 32, Wishbone address width

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- wbs_stb_i  in  1  Wishbone strobe
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_we_i  in  1  1 = write; cache never acks writes
- wbs_adr_i  in  ADDR_W  byte address
- wbs_ack_o  out  1  single-cycle read acknowledge
- wbs_dat_o  out  32  read data; 0 when ack low
- cache_flush  in  1  pulse; invalidate all lines
- refill_req  out  1  level; held high for the whole refill
- refill_adr  out  ADDR_W  line-aligned base address of the refill
- bram_data_in  in  32  refill data beat
- bram_in_valid  in  1  beat valid; beats arrive in word order from offset 0

Behaviour:
- Address split, with OFF_W=log2(LINE_WORDS) and IDX_W=log2(NUM_LINES):
  - word offset = adr[OFF_W+1:2]
  - index = adr[OFF_W+IDX_W+1:OFF_W+2]
  - tag = adr[ADDR_W-1:OFF_W+IDX_W+2]
  - adr[1:0] is ignored.
- Request qualifier: req = stb & cyc & ~we.
- Hit condition: valid[index] and tag_mem[index] == tag.
- FSM states:
  - IDLE: on req & hit -> ACK; data word latched into the output register this cycle. On req & miss -> REFILL; latch index, tag and offset; beat counter = 0.
  - REFILL: refill_req=1; refill_adr = {tag, index, OFF_W+2 zero bits}. Each bram_in_valid writes bram_data_in into line[index][counter], then counter increments. When the beat with counter == LINE_WORDS-1 arrives: set tag_mem[index], set valid[index], go to ACK_MISS.
  - ACK / ACK_MISS: wbs_ack_o=1 for exactly one cycle; wbs_dat_o = latched word (ACK_MISS returns the word at the latched offset); then -> IDLE.
- Latency:
  - hit: ack on cycle N+1 after req sampled at N
  - miss: ack one cycle after the last beat
- bram_in_valid outside REFILL is ignored.
- Requester abandons mid-refill (stb or cyc low): refill still completes and the line becomes valid. ACK_MISS is suppressed (ack stays 0) if req is low in that cycle; FSM -> IDLE.
- Back-to-back reads: a new req is evaluated only in IDLE, so there is one idle cycle minimum between acks. A req still high in the ACK cycle is the same transfer and is not re-evaluated until IDLE.
- Write with stb&cyc&we in IDLE, matching a valid line: clear valid[index] next edge. No ack, no data change.
- cache_flush:
  - clears all valid bits next edge.
  - If asserted in REFILL, the refill completes and ack is given, but the completing line ends invalid.
  - Flush has priority over line-valid set in the same cycle.
- Reset:
  - all valid bits = 0, FSM = IDLE, counter = 0
  - wbs_ack_o=0, wbs_dat_o=0, refill_req=0, refill_adr=0
  - data and tag arrays are not reset.
  - Reset mid-refill aborts it; refill_req drops asynchronously.
- refill_adr is 0 whenever refill_req is 0.

Decomposition:
- Package icache_pkg holds:
  - state encoding: IDLE, REFILL, ACK, ACK_MISS
  - width functions for OFF_W, IDX_W, TAG_W
- Sub-module icache_line_ram: NUM_LINES*LINE_WORDS x 32 storage, synchronous write, combinational read; indexed by {index, offset}.
- Tag and valid arrays and the FSM stay in the top module.

Test Plan:
- Cold miss: read 0x0000_0024 (defaults) -> refill_req=1, refill_adr=0x0000_0020; 8 beats 0xA0..0xA7 -> ack one cycle after the last beat, dat=0xA1.
- Hit after fill: read 0x0000_0038 -> ack on next cycle, dat=0xA6, refill_req stays 0.
- Conflict eviction: read 0x0000_00A0 (same index 1, new tag) -> refill at 0x0000_00A0. Then reread 0x0000_0020 -> miss again.
- Write invalidation: write to 0x0000_0024 while line valid -> no ack. Next read of 0x0000_0024 -> refill_req asserted.
- Flush during refill: assert cache_flush at beat 3 -> ack still given with correct data; immediate reread of the same address misses.
- Abandon plus reset: drop stb at beat 4 -> no ack, line valid, later read hits. Then assert rst mid-refill -> outputs 0 and FSM IDLE; a later read of the same line misses.
